arm_fetch: RTL and testbench
============================

# arm_fetch

Instruction fetch unit: the producer end of the instruction stream consumed by `arm_decode`. It issues word reads to instruction memory over a single-outstanding req/ack handshake and buffers returned words with their PCs in a small prefetch FIFO. It presents them to decode with a valid/ready handshake. A branch redirect (the `pc_we`/`pc_in` path) flushes the buffer and squashes any in-flight read.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, default 2: prefetch entries; power of two, ≥2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `imem_req` out 1: read request; held high until `imem_ack`.
- `imem_addr` out 32: word address; stable while `imem_req` is high.
- `imem_ack` in 1: read complete; valid only while `imem_req` is high.
- `imem_rdata` in 32: instruction word; sampled on `imem_ack`.
- `inst` out 32: head-of-FIFO instruction, wired to `arm_decode.inst`.
- `inst_pc` out 32: address of `inst`.
- `inst_valid` out 1: FIFO not empty.
- `inst_ready` in 1: decode accepts the head entry this cycle.
- `redirect` in 1: branch taken; flush and refetch.
- `redirect_pc` in 32: new fetch address; bits [1:0] ignored and forced to 0.

## Operation
- Registered state: `fetch_pc` (next address to request), FIFO `count`, FSM `state` ∈ {IDLE, BUSY, SQUASH}.
- `imem_req` = (state ≠ IDLE). `imem_addr` is a register loaded on entry to BUSY.
- Invariant: `count` + (state==BUSY) ≤ FIFO_DEPTH. A push can never hit a full FIFO.
- FSM transitions:
  - **IDLE:** if `count` < FIFO_DEPTH, go to BUSY and load `imem_addr` ← `fetch_pc`.
  - **BUSY, on `imem_ack`:**
    - Push {`imem_rdata`, `imem_addr`}.
    - `fetch_pc` ← `imem_addr` + 4, wrapping modulo 2^32.
    - If (count_next + 1) ≤ FIFO_DEPTH, stay in BUSY with `imem_addr` ← `imem_addr` + 4. This gives back-to-back requests.
    - Otherwise go to IDLE.
  - **SQUASH:** hold the old `imem_addr`. On `imem_ack`, drop the data, go to BUSY and load `imem_addr` ← `fetch_pc`.
- Pop on `inst_valid && inst_ready`. count_next = count + push − pop.
- `redirect` has priority over everything else in the same cycle:
  - `count` ← 0; any same-cycle pop or push is discarded.
  - `fetch_pc` ← {redirect_pc[31:2], 2'b00}.
  - From IDLE: go to BUSY next edge with `imem_addr` ← the new pc.
  - From BUSY without ack: go to SQUASH.
  - From BUSY with ack: data dropped; go to BUSY with `imem_addr` ← the new pc.
  - From SQUASH without ack: stay in SQUASH with the updated `fetch_pc`. Only the latest redirect target is fetched.
  - From SQUASH with ack: go to BUSY with the new pc.
- Reset values:
  - state IDLE, `fetch_pc` = `RESET_PC`, `count` 0.
  - `imem_req` 0, `imem_addr` = `RESET_PC`.
  - `inst_valid` 0, `inst` 0, `inst_pc` 0 (FIFO storage reset to 0).
- Reset mid-transaction abandons the outstanding read immediately. Instruction memory must tolerate `imem_req` dropping without ack.

## Timing
- First `imem_req` is high in the first cycle after the first rising edge following `rst_n` release, with `imem_addr` = `RESET_PC`.
- `imem_ack` sampled at edge N → `inst_valid` high after edge N. Fetch-to-decode latency is memory latency + 1.
- With zero-wait memory (ack in the same cycle as req) and `inst_ready` held high: one instruction per cycle sustained after a one-cycle startup.
- Redirect sampled at edge R:
  - `inst_valid` is 0 after R.
  - The first redirected instruction is valid no earlier than R + 2, plus the squash wait if a read was outstanding.
- `inst` and `inst_pc` change only on a pop, a push into an empty FIFO, or a redirect.

## Structure
- The shared defines header holds:
  - `FETCH_IDLE`, `FETCH_BUSY`, `FETCH_SQUASH` (2-bit encodings).
  - `INST_WIDTH` = 32.
  - `PC_INC` = 4.
- One sub-module, `arm_fetch_fifo`: synchronous FIFO with push, pop and synchronous flush. Each entry is 64 bits {inst, pc}. Outputs are `count` and the head entry, and the FIFO asynchronously resets to empty.

## Test plan
1. Reset, zero-wait ack, `inst_ready` = 1 → `inst_pc` sequence 0, 4, 8, 12 on consecutive cycles; first valid at cycle 2.
2. `inst_ready` = 0 with FIFO_DEPTH = 2 → exactly two acks occur, then `imem_req` stays 0. Raising ready resumes fetching at 8.
3. 3-cycle memory latency and `redirect` (pc 0x100) asserted during the wait:
   - The old word is dropped and not presented.
   - Next `imem_addr` = 0x100.
   - First `inst_pc` = 0x100.
4. `redirect` with `redirect_pc` = 0x203 in the same cycle as an ack and a pop → FIFO empty, the acked word is dropped, next `imem_addr` = 0x200.
5. `redirect` to 0xFFFF_FFFC with zero-wait memory → `inst_pc` sequence 0xFFFF_FFFC, then 0x0000_0000 (wrap-around).
6. `rst_n` asserted while `imem_req` is high → `imem_req`, `inst_valid` and `count` go to 0 immediately. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the arm_fetch instruction fetch unit.
package arm_fetch_pkg;

    localparam int          INST_WIDTH = 32;
    localparam logic [31:0] PC_INC     = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'b00,
        FETCH_BUSY   = 2'b01,
        FETCH_SQUASH = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [31:0]           pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arm_fetch_fifo.sv
// Prefetch buffer: {inst, pc} entries, synchronous flush, head always visible.
module arm_fetch_fifo
    import arm_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too, so inst/inst_pc read 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/arm_fetch.sv
// Instruction fetch: single-outstanding imem reads into a prefetch FIFO,
// valid/ready toward decode, redirect flushes and squashes the in-flight read.
module arm_fetch
    import arm_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [31:0]           imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [INST_WIDTH-1:0] inst,
    output logic [31:0]           inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e  state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   addr_next;
    logic [31:0]   target;
    logic [CW-1:0] count, count_next;
    logic          push, pop;
    fetch_entry_t  head;

    assign target     = word_align(redirect_pc);
    assign push       = (state == FETCH_BUSY) && imem_ack && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign count_next = count + CW'(push) - CW'(pop);

    always_comb begin
        // NOTE: defaults first so every path assigns every output: no latches.
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = imem_addr;
        unique case (state)
            FETCH_IDLE: begin
                if (redirect) begin
                    state_next    = FETCH_BUSY;
                    fetch_pc_next = target;
                    addr_next     = target;
                end else if (count < DEPTH_C) begin
                    state_next = FETCH_BUSY;
                    addr_next  = fetch_pc;
                end
            end
            FETCH_BUSY: begin
                if (imem_ack && redirect) begin
                    fetch_pc_next = target;
                    addr_next     = target;
                end else if (imem_ack) begin
                    fetch_pc_next = imem_addr + PC_INC;
                    // Keep requesting only while the next word is guaranteed a slot.
                    if (count_next < DEPTH_C) addr_next = imem_addr + PC_INC;
                    else                      state_next = FETCH_IDLE;
                end else if (redirect) begin
                    state_next    = FETCH_SQUASH;
                    fetch_pc_next = target;
                end
            end
            FETCH_SQUASH: begin
                if (redirect) fetch_pc_next = target;
                if (imem_ack) begin
                    state_next = FETCH_BUSY;
                    addr_next  = redirect ? target : fetch_pc;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH_IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_addr <= addr_next;
        end
    end

    arm_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{inst: imem_rdata, pc: imem_addr}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign imem_req   = (state != FETCH_IDLE);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign inst_valid = (count != '0);

endmodule

// File: tb/tb_arm_fetch.sv
// Self-checking bench for arm_fetch: memory model, instruction-stream scoreboard,
// directed scenarios and a randomized run.
module tb_arm_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    arm_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus configuration, written by the main process just after a rising edge.
    int          cfg_lat_min = 0;
    int          cfg_lat_max = 0;
    int          cfg_ready_pct = 100;
    int          cfg_redir_pct = 0;
    bit          redir_pending = 0;
    int          redir_mode = 0;
    logic [31:0] redir_target = '0;

    // Bench model state.
    int          cyc;
    bit          mem_pending, req_hold, after_redir, fire;
    int          mem_wait, mem_lat, n_pops;
    logic [31:0] held_addr, exp_pc;
    logic [31:0] ack_q[$];
    logic [31:0] pop_q[$];
    logic [31:0] popc_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of memory, decode and redirect behaviour, run on the falling edge.
    task automatic drive_step();
        if (!rst_n) begin
            imem_ack    = 1'b0;
            redirect    = 1'b0;
            mem_pending = 1'b0;
            req_hold    = 1'b0;
            after_redir = 1'b0;
            exp_pc      = RESET_PC;
            return;
        end
        if (req_hold) begin
            check("req_held", imem_req, 1);
            check("addr_stable", imem_addr, held_addr);
        end
        if (after_redir) check("valid_after_redirect", inst_valid, 0);
        if (inst_valid) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst", inst, mem_word(exp_pc));
        end

        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!mem_pending) begin
                mem_wait = 0;
                mem_lat  = $urandom_range(cfg_lat_max, cfg_lat_min);
            end
            if (mem_wait >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                mem_wait++;
            end
        end
        mem_pending = imem_req && !imem_ack;
        req_hold    = mem_pending;
        held_addr   = imem_addr;

        inst_ready = (cfg_ready_pct >= 100) ? 1'b1 : ($urandom_range(99, 0) < cfg_ready_pct);

        fire = 1'b0;
        if (redir_pending) begin
            case (redir_mode)
                1:       fire = imem_req && !imem_ack;
                2:       fire = imem_ack && inst_valid && inst_ready;
                default: fire = 1'b1;
            endcase
        end else if (cfg_redir_pct > 0 && $urandom_range(99, 0) < cfg_redir_pct) begin
            fire         = 1'b1;
            redir_target = $urandom;
        end
        redirect    = fire;
        redirect_pc = fire ? redir_target : $urandom;
        if (fire) redir_pending = 1'b0;

        if (imem_ack) ack_q.push_back(imem_addr);
        if (inst_valid && inst_ready && !redirect) begin
            pop_q.push_back(inst_pc);
            popc_q.push_back(cyc);
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (redirect) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
            ack_q.delete();
            pop_q.delete();
            popc_q.delete();
        end
        after_redir = redirect;
    endtask

    initial forever begin
        @(negedge clk);
        drive_step();
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        redir_pending = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ack_q.delete();
        pop_q.delete();
        popc_q.delete();
    endtask

    task automatic set_cfg(input int lmin, input int lmax, input int rdy);
        cfg_lat_min   = lmin;
        cfg_lat_max   = lmax;
        cfg_ready_pct = rdy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset values.
        #12;
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);

        // 1: zero-wait memory, ready held high.
        set_cfg(0, 0, 100);
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        check("t1_first_valid_cycle", at(popc_q, 0), 2);
        check("t1_pc0", at(pop_q, 0), 32'h0);
        check("t1_pc1", at(pop_q, 1), 32'h4);
        check("t1_pc2", at(pop_q, 2), 32'h8);
        check("t1_pc3", at(pop_q, 3), 32'hC);
        check("t1_pc3_cycle", at(popc_q, 3), 5);

        // 2: decode stalled, two-entry buffer fills and fetch stops.
        set_cfg(0, 0, 0);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check("t2_ack_count", ack_q.size(), 2);
        check("t2_ack0", at(ack_q, 0), 32'h0);
        check("t2_ack1", at(ack_q, 1), 32'h4);
        check("t2_req_idle", imem_req, 0);
        check("t2_head_pc", inst_pc, 32'h0);
        cfg_ready_pct = 100;
        repeat (6) @(posedge clk);
        #1;
        check("t2_resume_addr", at(ack_q, 2), 32'h8);
        check("t2_pop2", at(pop_q, 2), 32'h8);

        // 3: slow memory, redirect while a read is outstanding.
        set_cfg(3, 3, 100);
        do_reset();
        redir_target = 32'h0000_0100; redir_mode = 1; redir_pending = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("t3_redirect_fired", redir_pending, 0);
        check("t3_squashed_ack", at(ack_q, 0), 32'h0);
        check("t3_next_addr", at(ack_q, 1), 32'h100);
        check("t3_first_pc", at(pop_q, 0), 32'h100);

        // 4: redirect coinciding with ack and pop, unaligned target.
        set_cfg(0, 0, 100);
        do_reset();
        repeat (4) @(posedge clk);
        redir_target = 32'h0000_0203; redir_mode = 2; redir_pending = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t4_redirect_fired", redir_pending, 0);
        check("t4_next_addr", at(ack_q, 0), 32'h200);
        check("t4_first_pc", at(pop_q, 0), 32'h200);
        check("t4_second_pc", at(pop_q, 1), 32'h204);

        // 5: redirect to the top word, fetch wraps to zero.
        @(posedge clk);
        redir_target = 32'hFFFF_FFFC; redir_mode = 0; redir_pending = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t5_top_pc", at(pop_q, 0), 32'hFFFF_FFFC);
        check("t5_wrap_pc", at(pop_q, 1), 32'h0);
        check("t5_back_to_back", at(popc_q, 1) - at(popc_q, 0), 1);

        // 6: reset asserted with a read outstanding and data buffered.
        set_cfg(3, 3, 0);
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            found = inst_valid && imem_req;
        end
        check("t6_reached_busy", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_req_dropped", imem_req, 0);
        check("t6_valid_dropped", inst_valid, 0);
        check("t6_inst_pc_cleared", inst_pc, 0);
        cfg_ready_pct = 100;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ack_q.delete(); pop_q.delete(); popc_q.delete();
        repeat (12) @(posedge clk);
        #1;
        check("t6_restart_addr", at(ack_q, 0), RESET_PC);
        check("t6_restart_pc", at(pop_q, 0), RESET_PC);

        // Randomized run: latency, back-pressure and redirects all random.
        set_cfg(0, 3, 70);
        cfg_redir_pct = 4;
        do_reset();
        n_pops = 0;
        repeat (3000) @(posedge clk);
        cfg_redir_pct = 0;
        #1;
        check("rand_progress", (n_pops > 200), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
